dm_arbiter: RTL and testbench

Arbiter that shares the single-port data memory between the pipeline MEM stage (CPU port) and a DMA/loader port. The CPU has default priority; a starvation counter forces a bounded DMA burst when the DMA port has been denied too long, stalling the CPU for its duration. It sits between the MEM-stage pipeline register and the DM. It steers address, write enable, write data and PC to the DM, and returns the DM's combinational read data to both requesters.

---
 rtl/dm_arbiter_pkg.sv | 18 +
 rtl/dm_arbiter_if.sv | 46 ++++
 rtl/dm_arbiter_sat_counter.sv | 40 ++++
 rtl/dm_arbiter.sv | 131 +++++++++++++
 tb/tb_dm_arbiter.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: ownership state encoding,
// default widths and the counter-width helper.
package dm_arbiter_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DATA_W     = 32;

  typedef enum logic {
    CPU_OWN = 1'b0,
    DMA_OWN = 1'b1
  } arb_state_e;

  // One extra bit so the counter can hold the saturation value itself.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val) + 1;
  endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Request, grant and memory-side signals shared by the CPU port, the DMA port
// and the data memory; the arbiter uses the slave view.
interface dm_arbiter_if
  import dm_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wd;
  logic [DATA_W-1:0] cpu_pc;
  logic              cpu_gnt;
  logic              cpu_stall;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wd;
  logic              dma_gnt;

  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wd;
  logic [DATA_W-1:0] dm_pc;
  logic [DATA_W-1:0] dm_rd;
  logic [DATA_W-1:0] rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wd, cpu_pc,
    input  dma_req, dma_we, dma_addr, dma_wd,
    input  dm_rd,
    output cpu_gnt, cpu_stall, dma_gnt,
    output dm_we, dm_addr, dm_wd, dm_pc, rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wd, cpu_pc,
    output dma_req, dma_we, dma_addr, dma_wd,
    output dm_rd,
    input  cpu_gnt, cpu_stall, dma_gnt,
    input  dm_we, dm_addr, dm_wd, dm_pc, rdata
  );

endinterface

// File: rtl/dm_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over
// increment. Used for the DMA starvation count and the forced-burst count.
module arb_sat_counter
  import dm_arbiter_pkg::*;
#(
  parameter int MAX = 8,
  parameter int W   = cnt_width(MAX)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/dm_arbiter.sv
// Shares the single-port data memory between the MEM-stage CPU port and a
// DMA/loader port: CPU priority by default, bounded forced DMA bursts on starvation.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int MAX_WAIT = 8,
  parameter int BURST    = 4
) (
  input  logic        clk,
  input  logic        reset,
  dm_arbiter_if.slave bus
);

  localparam int WAIT_W  = cnt_width(MAX_WAIT);
  localparam int BURST_W = cnt_width(BURST);

  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(MAX_WAIT - 1);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST - 1);

  arb_state_e state_d;
  arb_state_e state_q;

  logic cpu_gnt;
  logic dma_gnt;

  logic               wait_inc;
  logic               wait_clr;
  logic               wait_hit;
  logic [WAIT_W-1:0]  wait_cnt;

  logic               burst_inc;
  logic               burst_clr;
  logic               burst_hit;
  logic [BURST_W-1:0] burst_cnt;

  logic              steer_we;
  logic [ADDR_W-1:0] steer_addr;
  logic [DATA_W-1:0] steer_wd;
  logic [DATA_W-1:0] steer_pc;

  // Zero-latency grants: the owning side wins, the other side only gets an
  // otherwise idle cycle. Nothing is granted while reset is held.
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (!reset) begin
      if (state_q == CPU_OWN) begin
        cpu_gnt = bus.cpu_req;
        dma_gnt = bus.dma_req & ~bus.cpu_req;
      end else begin
        dma_gnt = bus.dma_req;
        cpu_gnt = bus.cpu_req & ~bus.dma_req;
      end
    end
  end

  always_comb begin
    wait_inc  = (state_q == CPU_OWN) & bus.dma_req & ~dma_gnt;
    wait_clr  = (state_q == DMA_OWN) | ~bus.dma_req | dma_gnt;
    wait_hit  = wait_inc & (wait_cnt == WAIT_LAST);
    burst_inc = (state_q == DMA_OWN) & dma_gnt;
    burst_hit = burst_inc & (burst_cnt == BURST_LAST);
    burst_clr = (state_q == CPU_OWN) | ~bus.dma_req | burst_hit;
  end

  arb_sat_counter #(
    .MAX (MAX_WAIT)
  ) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (wait_clr),
    .inc   (wait_inc),
    .cnt   (wait_cnt)
  );

  arb_sat_counter #(
    .MAX (BURST)
  ) u_burst_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (burst_clr),
    .inc   (burst_inc),
    .cnt   (burst_cnt)
  );

  // A dropped DMA request ends the burst early so the CPU is not stalled for nothing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CPU_OWN: if (wait_hit) state_d = DMA_OWN;
      DMA_OWN: if (!bus.dma_req || burst_hit) state_d = CPU_OWN;
      default: state_d = CPU_OWN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CPU_OWN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    steer_we   = 1'b0;
    steer_addr = '0;
    steer_wd   = '0;
    steer_pc   = '0;
    if (cpu_gnt) begin
      steer_we   = bus.cpu_we;
      steer_addr = bus.cpu_addr;
      steer_wd   = bus.cpu_wd;
      steer_pc   = bus.cpu_pc;
    end else if (dma_gnt) begin
      steer_we   = bus.dma_we;
      steer_addr = bus.dma_addr;
      steer_wd   = bus.dma_wd;
    end
  end

  assign bus.cpu_gnt   = cpu_gnt;
  assign bus.dma_gnt   = dma_gnt;
  assign bus.cpu_stall = bus.cpu_req & ~cpu_gnt & ~reset;
  assign bus.dm_we     = steer_we;
  assign bus.dm_addr   = steer_addr;
  assign bus.dm_wd     = steer_wd;
  assign bus.dm_pc     = steer_pc;
  assign bus.rdata     = bus.dm_rd;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios with literal expectations plus a
// per-cycle comparison against a priority/starvation model of the arbiter.
module tb_dm_arbiter;

  localparam int MAX_WAIT = 8;
  localparam int BURST    = 4;

  logic clk;
  logic reset;

  dm_arbiter_if #(.ADDR_W(12)) bus ();

  dm_arbiter #(
    .ADDR_W   (12),
    .MAX_WAIT (MAX_WAIT),
    .BURST    (BURST)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  bit [31:0] mem     [4096];
  bit [31:0] ref_mem [4096];

  int n_total = 0;
  int n_pass  = 0;

  int m_starve = 0;
  int m_forced = 0;

  logic        e_cpu_gnt = 1'b0;
  logic        e_dma_gnt = 1'b0;
  logic        e_stall;
  logic        e_we;
  logic [11:0] e_addr;
  logic [31:0] e_wd;
  logic [31:0] e_pc;
  logic [31:0] e_rd;

  int run_dwait  = 0;
  int run_cstall = 0;
  int max_dwait  = 0;
  int max_cstall = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.dm_rd = mem[bus.dm_addr];

  // Data memory: writes commit at the edge that ends the grant cycle.
  initial begin
    forever begin
      @(posedge clk);
      if (bus.dm_we === 1'b1) mem[bus.dm_addr] = bus.dm_wd;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic cr, input logic cw, input logic [11:0] ca,
                               input logic [31:0] cd, input logic [31:0] pc,
                               input logic dr, input logic dw, input logic [11:0] da,
                               input logic [31:0] dd);
    @(posedge clk);
    #1;
    bus.cpu_req  = cr;
    bus.cpu_we   = cw;
    bus.cpu_addr = ca;
    bus.cpu_wd   = cd;
    bus.cpu_pc   = pc;
    bus.dma_req  = dr;
    bus.dma_we   = dw;
    bus.dma_addr = da;
    bus.dma_wd   = dd;
    @(negedge clk);
  endtask

  // Model: CPU has priority unless a forced burst is pending; a burst is
  // armed after MAX_WAIT consecutive denials and lasts up to BURST grants.
  initial begin
    forever begin
      @(negedge clk);
      e_cpu_gnt = 1'b0;
      e_dma_gnt = 1'b0;
      if (!reset) begin
        if (m_forced > 0 && bus.dma_req) begin
          e_dma_gnt = 1'b1;
        end else if (bus.cpu_req) begin
          e_cpu_gnt = 1'b1;
        end else if (bus.dma_req) begin
          e_dma_gnt = 1'b1;
        end
      end
      e_stall = !reset && bus.cpu_req && !e_cpu_gnt;
      e_we = 1'b0; e_addr = '0; e_wd = '0; e_pc = '0;
      if (e_cpu_gnt) begin
        e_we = bus.cpu_we; e_addr = bus.cpu_addr; e_wd = bus.cpu_wd; e_pc = bus.cpu_pc;
      end else if (e_dma_gnt) begin
        e_we = bus.dma_we; e_addr = bus.dma_addr; e_wd = bus.dma_wd;
      end
      e_rd = ref_mem[e_addr];

      checkOutput("cpu_gnt", bus.cpu_gnt, e_cpu_gnt);
      checkOutput("dma_gnt", bus.dma_gnt, e_dma_gnt);
      checkOutput("cpu_stall", bus.cpu_stall, e_stall);
      checkOutput("dm_we", bus.dm_we, e_we);
      checkOutput("dm_addr", bus.dm_addr, e_addr);
      checkOutput("dm_wd", bus.dm_wd, e_wd);
      checkOutput("dm_pc", bus.dm_pc, e_pc);
      checkOutput("rdata", bus.rdata, e_rd);
      checkOutput("mutex", bus.cpu_gnt & bus.dma_gnt, 1'b0);

      if (e_we) ref_mem[e_addr] = e_wd;

      if (reset) begin
        m_starve = 0;
        m_forced = 0;
      end else if (m_forced > 0) begin
        if (e_dma_gnt) m_forced--;
        else m_forced = 0;
      end else if (bus.dma_req && !e_dma_gnt) begin
        m_starve++;
        if (m_starve == MAX_WAIT) begin
          m_forced = BURST;
          m_starve = 0;
        end
      end else begin
        m_starve = 0;
      end

      if (reset) begin
        run_dwait = 0;
        run_cstall = 0;
      end else begin
        if (bus.dma_req && !bus.dma_gnt) run_dwait++;
        else run_dwait = 0;
        if (bus.cpu_stall) run_cstall++;
        else run_cstall = 0;
        if (run_dwait > max_dwait) max_dwait = run_dwait;
        if (run_cstall > max_cstall) max_cstall = run_cstall;
      end
    end
  end

  initial begin
    reset        = 1'b1;
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b1;
    bus.cpu_addr = 12'h005;
    bus.cpu_wd   = 32'h12345678;
    bus.cpu_pc   = 32'h00000040;
    bus.dma_req  = 1'b1;
    bus.dma_we   = 1'b1;
    bus.dma_addr = 12'h006;
    bus.dma_wd   = 32'h87654321;

    @(negedge clk);
    checkOutput("rst_cpu_gnt", bus.cpu_gnt, 1'b0);
    checkOutput("rst_dma_gnt", bus.dma_gnt, 1'b0);
    checkOutput("rst_cpu_stall", bus.cpu_stall, 1'b0);
    checkOutput("rst_dm_we", bus.dm_we, 1'b0);
    checkOutput("rst_dm_addr", bus.dm_addr, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(0, 0, 12'h000, 32'h0, 32'h0, 0, 0, 12'h000, 32'h0);

    $display("[TB] CPU write then read");
    applyStimulus(1, 1, 12'h004, 32'hDEADBEEF, 32'h00000100, 0, 0, 12'h000, 32'h0);
    checkOutput("t1_cpu_gnt", bus.cpu_gnt, 1'b1);
    checkOutput("t1_dm_we", bus.dm_we, 1'b1);
    checkOutput("t1_dm_addr", bus.dm_addr, 32'h004);
    checkOutput("t1_dm_pc", bus.dm_pc, 32'h00000100);
    applyStimulus(1, 0, 12'h004, 32'h0, 32'h00000104, 0, 0, 12'h000, 32'h0);
    checkOutput("t1_rdata", bus.rdata, 32'hDEADBEEF);

    $display("[TB] DMA idle fill");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 12'h000, 32'h0, 32'h0, 1, 1, 12'h010 + 12'(i), 32'hCAFE0000 + 32'(i));
      checkOutput("t2_dma_gnt", bus.dma_gnt, 1'b1);
      checkOutput("t2_cpu_stall", bus.cpu_stall, 1'b0);
      checkOutput("t2_dm_pc", bus.dm_pc, 32'h0);
    end
    applyStimulus(1, 0, 12'h012, 32'h0, 32'h00000108, 0, 0, 12'h000, 32'h0);
    checkOutput("t2_rdata", bus.rdata, 32'hCAFE0002);
    applyStimulus(0, 0, 12'h000, 32'h0, 32'h0, 0, 0, 12'h000, 32'h0);

    $display("[TB] starvation period");
    for (int c = 0; c < 24; c++) begin
      applyStimulus(1, 0, 12'h020, 32'h0, 32'h00000200, 1, 1, 12'h200, 32'h5555AAAA);
      checkOutput("t3_cpu_gnt", bus.cpu_gnt, (c % 12) < 8);
      checkOutput("t3_dma_gnt", bus.dma_gnt, (c % 12) >= 8);
      checkOutput("t3_cpu_stall", bus.cpu_stall, (c % 12) >= 8);
    end
    applyStimulus(0, 0, 12'h000, 32'h0, 32'h0, 0, 0, 12'h000, 32'h0);

    $display("[TB] early burst end");
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1, 0, 12'h021, 32'h0, 32'h00000300, 1, 1, 12'h210, 32'h0000BEEF);
      checkOutput("t4_pre_cpu_gnt", bus.cpu_gnt, 1'b1);
    end
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1, 0, 12'h021, 32'h0, 32'h00000300, 1, 1, 12'h210, 32'h0000BEEF);
      checkOutput("t4_beat_dma_gnt", bus.dma_gnt, 1'b1);
      checkOutput("t4_beat_stall", bus.cpu_stall, 1'b1);
    end
    applyStimulus(1, 0, 12'h021, 32'h0, 32'h00000300, 0, 0, 12'h000, 32'h0);
    checkOutput("t4_drop_cpu_gnt", bus.cpu_gnt, 1'b1);
    checkOutput("t4_drop_stall", bus.cpu_stall, 1'b0);
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1, 0, 12'h022, 32'h0, 32'h00000304, 1, 0, 12'h211, 32'h0);
      checkOutput("t4_post_cpu_gnt", bus.cpu_gnt, 1'b1);
    end
    applyStimulus(1, 0, 12'h022, 32'h0, 32'h00000304, 1, 0, 12'h211, 32'h0);
    checkOutput("t4_refire_dma_gnt", bus.dma_gnt, 1'b1);
    applyStimulus(0, 0, 12'h000, 32'h0, 32'h0, 0, 0, 12'h000, 32'h0);

    $display("[TB] reset mid-burst");
    for (int c = 0; c < 9; c++) begin
      applyStimulus(1, 0, 12'h023, 32'h0, 32'h00000400, 1, 1, 12'h300, 32'h11111111);
    end
    checkOutput("t5_beat1_dma_gnt", bus.dma_gnt, 1'b1);
    checkOutput("t5_beat1_dm_we", bus.dm_we, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("t5_rst_dm_we", bus.dm_we, 1'b0);
    checkOutput("t5_rst_dma_gnt", bus.dma_gnt, 1'b0);
    checkOutput("t5_rst_cpu_stall", bus.cpu_stall, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("t5_rel_cpu_gnt", bus.cpu_gnt, 1'b1);
    checkOutput("t5_rel_dma_gnt", bus.dma_gnt, 1'b0);
    applyStimulus(0, 0, 12'h000, 32'h0, 32'h0, 0, 0, 12'h000, 32'h0);

    $display("[TB] random traffic");
    max_dwait  = 0;
    max_cstall = 0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      if (!(bus.cpu_req && !e_cpu_gnt)) begin
        bus.cpu_req  = ($urandom_range(0, 99) < 70);
        bus.cpu_we   = 1'($urandom_range(0, 1));
        bus.cpu_addr = 12'($urandom_range(0, 63));
        bus.cpu_wd   = $urandom();
        bus.cpu_pc   = $urandom();
      end
      if (!(bus.dma_req && !e_dma_gnt)) begin
        bus.dma_req  = ($urandom_range(0, 99) < 60);
        bus.dma_we   = 1'($urandom_range(0, 1));
        bus.dma_addr = 12'($urandom_range(0, 63));
        bus.dma_wd   = $urandom();
      end
    end
    applyStimulus(0, 0, 12'h000, 32'h0, 32'h0, 0, 0, 12'h000, 32'h0);
    checkOutput("max_dma_wait_ok", max_dwait <= MAX_WAIT, 1'b1);
    checkOutput("max_cpu_stall_ok", max_cstall <= BURST, 1'b1);
    checkOutput("dma_wait_reached", max_dwait == MAX_WAIT, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
